// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with valid/ready handshake and iterative multu/divu
// Optional: SEQ_ALU_OVF_EN adds the signed add/sub overflow flag on ovf.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             dz,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_n;
  logic [SHW-1:0]   cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;

  logic             accept, is_iter, div0, last;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic [WIDTH:0]   mul_sum, div_rr, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign busy     = (state == RUN);
  assign in_ready = ~busy;
  assign done     = (state == FIN);
  assign accept   = in_valid & in_ready;
  assign is_iter  = op[2] & op[1];
  assign div0     = (op == 3'b111) && (b == '0);
  assign last     = (cnt == SHW'(WIDTH - 1));
  assign sum      = a + b;
  assign diff     = a - b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: begin
        if (accept)             state_n = (is_iter && !div0) ? RUN : FIN;
        else if (state == FIN)  state_n = IDLE;
      end
      RUN:     if (last) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      3'b000:  alu_res = sum;
      3'b001:  alu_res = diff;
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a >> b[SHW-1:0];
      3'b101:  alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      default: alu_res = '0;
    endcase
  end

  // One iteration step: shift-add (acc_lo holds multiplier) or restoring divide (acc_lo holds dividend/quotient).
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_rr   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_rr - {1'b0, opnd};
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = div_diff[WIDTH] ? div_rr[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      result <= '0;
      hi     <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op[0];
      acc_hi <= '0;
      acc_lo <= op[0] ? a : b;
      opnd   <= op[0] ? b : a;
      dz     <= div0;
      if (!is_iter) begin
        result <= alu_res;
        hi     <= '0;
      end else if (div0) begin
        result <= '1;
        hi     <= a;
      end
    end else if (state == RUN) begin
      cnt    <= cnt + SHW'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last) begin
        result <= step_lo;
        hi     <= step_hi;
      end
    end
  end

`ifdef SEQ_ALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      case (op)
        3'b000:  ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        3'b001:  ovf <= (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        default: ovf <= 1'b0;
      endcase
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - table-driven self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;

  localparam int W = 32;
`ifdef SEQ_ALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dz, ovf;
  logic [W-1:0] result, hi;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .hi(hi), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res, hi;
    logic         dz, ovf;
    int           lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one op, wait (bounded) for done; returns latency in edges and busy-cycle count.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input bit poke, output int lat, output int bcnt);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (poke && (lat == 5 || lat == 20)) begin
        in_valid = 1'b1; op = 3'b000; a = 32'h1; b = 32'h1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt;
    vecs[0]  = '{3'b101, 32'hf0001000, 32'h1,        32'hf8000800, 32'h0,        1'b0, 1'b0, 1};
    vecs[1]  = '{3'b100, 32'hf0001000, 32'h1,        32'h78000800, 32'h0,        1'b0, 1'b0, 1};
    vecs[2]  = '{3'b000, 32'hf0001000, 32'h1,        32'hf0001001, 32'h0,        1'b0, 1'b0, 1};
    vecs[3]  = '{3'b001, 32'h3,        32'h5,        32'hfffffffe, 32'h0,        1'b0, 1'b0, 1};
    vecs[4]  = '{3'b010, 32'hf0f0ff00, 32'h0ff0f0f0, 32'h00f0f000, 32'h0,        1'b0, 1'b0, 1};
    vecs[5]  = '{3'b011, 32'hf0f0ff00, 32'h0ff0f0f0, 32'hfff0fff0, 32'h0,        1'b0, 1'b0, 1};
    vecs[6]  = '{3'b100, 32'h80000000, 32'h21,       32'h40000000, 32'h0,        1'b0, 1'b0, 1};
    vecs[7]  = '{3'b101, 32'h80000000, 32'h1f,       32'hffffffff, 32'h0,        1'b0, 1'b0, 1};
    vecs[8]  = '{3'b110, 32'hffffffff, 32'h2,        32'hfffffffe, 32'h1,        1'b0, 1'b0, 33};
    vecs[9]  = '{3'b111, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33};
    vecs[10] = '{3'b111, 32'd5,        32'd0,        32'hffffffff, 32'd5,        1'b1, 1'b0, 1};
    vecs[11] = '{3'b110, 32'hffffffff, 32'hffffffff, 32'h00000001, 32'hfffffffe, 1'b0, 1'b0, 33};
    vecs[12] = '{3'b111, 32'hffffffff, 32'h1,        32'hffffffff, 32'h0,        1'b0, 1'b0, 33};
    vecs[13] = '{3'b111, 32'd7,        32'd9,        32'd0,        32'd7,        1'b0, 1'b0, 33};
    vecs[14] = '{3'b000, 32'h7fffffff, 32'h1,        32'h80000000, 32'h0,        1'b0, 1'b1, 1};
    vecs[15] = '{3'b001, 32'h80000000, 32'h1,        32'h7fffffff, 32'h0,        1'b0, 1'b1, 1};
    vecs[16] = '{3'b110, 32'h12345678, 32'h10,       32'h23456780, 32'h1,        1'b0, 1'b0, 33};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset result", result, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset dz", {31'b0, dz}, 32'h0);
    chk("reset ovf", {31'b0, ovf}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
      chk($sformatf("v%0d result", i), result, vecs[i].res);
      chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d dz", i), {31'b0, dz}, {31'b0, vecs[i].dz});
      chk($sformatf("v%0d ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf & OVF_ON});
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d busy cycles", i), bcnt, (vecs[i].lat == 33) ? 32 : 0);
    end

    // and clears ovf left by the preceding sub
    run_op(3'b010, 32'hffffffff, 32'h0000ffff, 1'b0, lat, bcnt);
    chk("and result", result, 32'h0000ffff);
    chk("and ovf", {31'b0, ovf}, 32'h0);

    // multu with ignored in_valid pulses during busy
    run_op(3'b110, 32'hffffffff, 32'h2, 1'b1, lat, bcnt);
    chk("poke result", result, 32'hfffffffe);
    chk("poke hi", hi, 32'h1);
    chk("poke latency", lat, 33);
    chk("poke busy cycles", bcnt, 32);

    // back-to-back: sub accepted in the done cycle of a div-by-zero
    run_op(3'b111, 32'd5, 32'd0, 1'b0, lat, bcnt);
    chk("b2b div dz", {31'b0, dz}, 32'h1);
    chk("b2b in_ready in done", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b done", {31'b0, done}, 32'h1);
    chk("b2b result", result, 32'hfffffffe);
    chk("b2b hi", hi, 32'h0);
    chk("b2b dz", {31'b0, dz}, 32'h0);

    // reset mid-multu aborts with no done pulse
    @(negedge clk);
    in_valid = 1'b1; op = 3'b110; a = 32'hffffffff; b = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'h0);
    chk("abort done", {31'b0, done}, 32'h0);
    chk("abort result", result, 32'h0);
    chk("abort hi", hi, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run_op(3'b000, 32'd2, 32'd3, 1'b0, lat, bcnt);
    chk("post-reset result", result, 32'd5);
    chk("post-reset latency", lat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
